// File: rtl/rf_rx_framer.sv
// Framer behind the RX down-sampler: groups 2-SPC words into fixed-length packets
// and buffers them for an AXI-Stream consumer, dropping whole packets on overflow.
module rf_rx_framer #(
  parameter int unsigned FIFO_AWIDTH = 5,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      i_tdata,
  input  logic             i_tvalid,
  input  logic             cfg_enable,
  input  logic [LEN_W-1:0] cfg_words_per_pkt,
  input  logic             clear_overflow,
  output logic [63:0]      o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             active,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AWIDTH;
  localparam int unsigned LW    = FIFO_AWIDTH + 1;
  localparam int unsigned CW    = (LEN_W > LW) ? LEN_W : LW;
  localparam logic [LW:0] DEPTH_X = (LW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t                 state, state_nxt;
  logic [64:0]            mem [DEPTH];
  logic [FIFO_AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AWIDTH-1:0] wrd_cnt, wrd_cnt_nxt;
  logic [LW-1:0]          fill, len_q, len_cfg, len_eff;
  logic [CW-1:0]          cfg_ext;
  logic                   at_boundary, pkt_start, admit, in_word, is_last;
  logic                   wr_en, rd_en, drop_evt;

  // Effective packet length, clamped to 1..DEPTH
  always_comb begin
    cfg_ext = CW'(cfg_words_per_pkt);
    len_cfg = LW'(DEPTH);
    if (cfg_ext == '0)
      len_cfg = LW'(1);
    else if (cfg_ext < CW'(DEPTH))
      len_cfg = LW'(cfg_ext);
  end

  // A counter of zero outside IDLE means the previous packet has ended
  assign at_boundary = (state == IDLE) || (wrd_cnt == '0);
  assign pkt_start   = i_tvalid && cfg_enable && at_boundary;
  assign admit       = ({1'b0, fill} + {1'b0, len_cfg}) <= DEPTH_X;
  assign len_eff     = pkt_start ? len_cfg : len_q;
  assign in_word     = i_tvalid && (pkt_start || ((state != IDLE) && (wrd_cnt != '0)));
  assign is_last     = ({1'b0, wrd_cnt} == (len_eff - LW'(1)));
  assign wrd_cnt_nxt = is_last ? '0 : wrd_cnt + FIFO_AWIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pkt_start)
      state_nxt = admit ? PASS : DROP;
    else if ((state != IDLE) && !cfg_enable && ((wrd_cnt == '0) || (in_word && is_last)))
      state_nxt = IDLE;
  end

  always_comb begin
    wr_en    = 1'b0;
    drop_evt = 1'b0;
    active   = (state != IDLE);
    if (pkt_start) begin
      wr_en    = admit;
      drop_evt = !admit;
    end else if (in_word && (state == PASS)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrd_cnt <= '0;
      len_q   <= LW'(1);
    end else begin
      if (in_word)
        wrd_cnt <= wrd_cnt_nxt;
      if (pkt_start)
        len_q <= len_cfg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop_evt) begin
      overflow   <= 1'b1;
      if (clear_overflow)
        drop_count <= CNT_W'(1);
      else if (drop_count != '1)
        drop_count <= drop_count + CNT_W'(1);
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // FIFO: head is read combinationally so a word is visible the cycle after its write
  assign o_tvalid = (fill != '0);
  assign rd_en    = o_tvalid && o_tready;
  assign o_tdata  = o_tvalid ? mem[rd_ptr][63:0] : '0;
  assign o_tlast  = o_tvalid ? mem[rd_ptr][64] : 1'b0;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {is_last, i_tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + FIFO_AWIDTH'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + FIFO_AWIDTH'(1);
      case ({wr_en, rd_en})
        2'b10:   fill <= fill + LW'(1);
        2'b01:   fill <= fill - LW'(1);
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_rx_framer.sv
// Scoreboard bench for rf_rx_framer: a word-level model predicts admitted words,
// drop accounting and the active flag; a negedge monitor checks the output stream.
`timescale 1ns/1ps
module tb_rf_rx_framer;

  localparam int unsigned D = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] i_tdata = '0;
  logic        i_tvalid = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_words_per_pkt = '0;
  logic        clear_overflow = 1'b0;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        active;
  logic        overflow;
  logic [31:0] drop_count;

  rf_rx_framer #(.FIFO_AWIDTH(5), .LEN_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .i_tdata(i_tdata), .i_tvalid(i_tvalid),
    .cfg_enable(cfg_enable), .cfg_words_per_pkt(cfg_words_per_pkt),
    .clear_overflow(clear_overflow), .o_tdata(o_tdata), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .active(active),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [64:0] w; int unsigned cyc; } exp_t;
  exp_t        sb[$];
  int unsigned n_tests = 0, n_fail = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pending inputs, applied together one step after each rising edge
  bit          nx_en = 0, nx_clr = 0, nx_rdy = 1;
  int unsigned nx_len = 4;

  int unsigned m_state = 0, m_cnt = 0, m_len = 1, m_drops = 0;
  bit          m_ovf = 0;
  bit          s_active = 0, s_ovf = 0;
  int unsigned s_drops = 0;

  task automatic step(input bit v, input logic [63:0] d);
    int unsigned l;
    bit          last, dropped, clr;
    @(posedge clk); #1;
    s_active = (m_state != 0); s_ovf = m_ovf; s_drops = m_drops;
    clr = nx_clr; nx_clr = 0;
    cfg_enable = nx_en; cfg_words_per_pkt = 16'(nx_len); clear_overflow = clr;
    o_tready = nx_rdy; i_tvalid = v; i_tdata = d;
    dropped = 0;
    l = (nx_len == 0) ? 1 : ((nx_len > D) ? D : nx_len);
    if (m_state != 0 && m_cnt == 0 && !nx_en) m_state = 0;
    if (v && nx_en && (m_state == 0 || m_cnt == 0)) begin
      m_len = l;
      if (int'(D) - sb.size() >= int'(l)) m_state = 1;
      else begin m_state = 2; dropped = 1; end
    end
    if (v && m_state != 0) begin
      last = (m_cnt == m_len - 1);
      if (m_state == 1) sb.push_back('{w: {last, d}, cyc: cyc + 1});
      m_cnt = last ? 0 : m_cnt + 1;
      if (last && !nx_en) m_state = 0;
    end
    if (dropped) begin
      m_ovf = 1;
      m_drops = clr ? 1 : ((m_drops == 32'hffff_ffff) ? m_drops : m_drops + 1);
    end else if (clr) begin
      m_ovf = 0; m_drops = 0;
    end
  endtask

  task automatic status(input string tag);
    @(negedge clk);
    chk({tag, "_active"}, active, s_active);
    chk({tag, "_overflow"}, overflow, s_ovf);
    chk({tag, "_drop_count"}, drop_count, s_drops);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) step(0, '0);
    step(0, '0);
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  bit          held = 0, lat_chk = 0;
  logic [64:0] held_w;
  int unsigned out_words = 0, out_lasts = 0;
  logic [63:0] out_last_data = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", o_tvalid, 1'b1);
        chk("hold_data", {o_tlast, o_tdata}, held_w);
      end
      held   = o_tvalid && !o_tready;
      held_w = {o_tlast, o_tdata};
      if (o_tvalid && o_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", o_tvalid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("word", {o_tlast, o_tdata}, e.w);
          if (lat_chk) chk("latency", cyc, e.cyc);
          out_words++;
          if (o_tlast) out_lasts++;
          out_last_data = o_tdata;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", o_tvalid, 1'b0);
    chk("rst_tlast", o_tlast, 1'b0);
    chk("rst_tdata", o_tdata, 64'd0);
    chk("rst_active", active, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop_count", drop_count, 32'd0);
    rst = 1'b0;

    // Back-to-back packets of 4
    nx_en = 1; nx_len = 4; nx_rdy = 1; lat_chk = 1;
    out_words = 0; out_lasts = 0;
    for (int i = 0; i < 12; i++) step(1, 64'(i));
    step(0, '0);
    status("t1");
    drain("t1");
    lat_chk = 0;
    chk("t1_words", out_words, 12);
    chk("t1_lasts", out_lasts, 3);
    chk("t1_overflow", overflow, 1'b0);

    // Overflow with stalled output
    nx_len = 8; nx_rdy = 0;
    out_words = 0; out_lasts = 0;
    for (int i = 0; i < 40; i++) step(1, 64'(i));
    step(0, '0);
    status("t2");
    chk("t2_drop_count", drop_count, 32'd1);
    chk("t2_overflow", overflow, 1'b1);
    chk("t2_stored", sb.size(), 32);
    nx_rdy = 1;
    drain("t2");
    chk("t2_words", out_words, 32);
    chk("t2_lasts", out_lasts, 4);
    chk("t2_last_data", out_last_data, 64'd31);

    // Plain clear
    nx_clr = 1; step(0, '0);
    step(0, '0);
    status("clr");
    chk("clr_overflow", overflow, 1'b0);
    chk("clr_drop_count", drop_count, 32'd0);

    // Clear coinciding with a drop
    nx_len = 16; nx_rdy = 0;
    for (int i = 0; i < 48; i++) step(1, 64'(600 + i));
    nx_clr = 1;
    for (int i = 0; i < 16; i++) step(1, 64'(700 + i));
    step(0, '0);
    status("clrdrop");
    chk("clrdrop_count", drop_count, 32'd1);
    chk("clrdrop_overflow", overflow, 1'b1);
    nx_rdy = 1;
    drain("clrdrop");

    // Enable dropped mid-packet
    nx_len = 4; nx_en = 1;
    step(1, 64'd200); step(1, 64'd201);
    nx_en = 0;
    step(1, 64'd202); step(1, 64'd203);
    status("t3a");
    chk("t3_active_mid", active, 1'b1);
    step(1, 64'd204);
    status("t3b");
    chk("t3_active_end", active, 1'b0);
    for (int i = 205; i < 208; i++) step(1, 64'(i));
    step(0, '0);
    drain("t3");

    // Gapped input, L=3
    nx_en = 1; nx_len = 3;
    out_words = 0; out_lasts = 0;
    for (int k = 0; k < 27; k++) step((k % 3) == 0, 64'(300 + k));
    drain("t4");
    chk("t4_words", out_words, 9);
    chk("t4_lasts", out_lasts, 3);

    // Length clamping
    nx_len = 0;
    out_words = 0; out_lasts = 0;
    for (int i = 0; i < 5; i++) step(1, 64'(400 + i));
    drain("t5a");
    chk("t5_len0_lasts", out_lasts, 5);
    nx_len = 100;
    out_words = 0; out_lasts = 0;
    for (int i = 0; i < 32; i++) step(1, 64'(1000 + i));
    repeat (3) step(0, '0);
    for (int i = 0; i < 32; i++) step(1, 64'(2000 + i));
    drain("t5b");
    status("t5");
    chk("t5_len100_words", out_words, 64);
    chk("t5_len100_lasts", out_lasts, 2);

    // Asynchronous reset mid-packet; overflow is still set from the clear/drop case
    nx_len = 8; nx_rdy = 0;
    for (int i = 0; i < 4; i++) step(1, 64'(500 + i));
    step(0, '0);
    chk("pre_rst_tvalid", o_tvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", o_tvalid, 1'b0);
    chk("arst_tlast", o_tlast, 1'b0);
    chk("arst_tdata", o_tdata, 64'd0);
    chk("arst_active", active, 1'b0);
    chk("arst_overflow", overflow, 1'b0);
    chk("arst_drop_count", drop_count, 32'd0);
    sb.delete();
    m_state = 0; m_cnt = 0; m_ovf = 0; m_drops = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    nx_len = 4; nx_rdy = 1; nx_en = 1;
    out_words = 0; out_lasts = 0;
    for (int i = 0; i < 8; i++) step(1, 64'(800 + i));
    drain("t6");
    chk("t6_words", out_words, 8);
    chk("t6_lasts", out_lasts, 2);
    chk("t6_last_data", out_last_data, 64'd807);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_rx_framer.md
Name: rf_rx_framer

Overview:
- Sits directly downstream of the 4-to-2 RX down-sampler. Consumes its 2 SPC (64-bit, two sc16 samples) stream on `clk`; that stream has a valid strobe and no backpressure.
- Groups words into fixed-length packets with `tlast`. Buffers them in a FIFO and presents a standard AXI-Stream master with `tready` to the packetizer/CHDR side.
- Input cannot be stalled, so overflow is handled by dropping whole packets. The packets that do reach the output are never partial.

Parameters:
- FIFO_AWIDTH, 5, log2 FIFO depth in 64-bit words (depth D = 2^FIFO_AWIDTH).
- LEN_W, 16, width of the packet-length configuration.
- CNT_W, 32, width of the drop counter.

Ports:
- clk  in  1  sample clock (same domain as the down-sampler's `clk`).
- rst  in  1  asynchronous, active-high reset.
- i_tdata  in  64  two samples; [31:0] is the earlier sample, [63:32] the later.
- i_tvalid  in  1  input word strobe; no backpressure.
- cfg_enable  in  1  capture enable.
- cfg_words_per_pkt  in  LEN_W  words per packet.
- clear_overflow  in  1  single-cycle pulse; clears `overflow` and `drop_count`.
- o_tdata  out  64  output word.
- o_tlast  out  1  last word of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream ready.
- active  out  1  high while the framer is in PASS or DROP.
- overflow  out  1  sticky flag: at least one packet has been dropped.
- drop_count  out  CNT_W  number of dropped packets; saturates at all-ones.

Behaviour:
- Reset (asynchronous, immediate):
  - o_tvalid=0, o_tlast=0, o_tdata=0, active=0, overflow=0, drop_count=0.
  - FIFO emptied, state=IDLE, word counter=0.
- Effective length L is fixed at packet start:
  - L = cfg_words_per_pkt, clamped to the range 1..D.
  - A value of 0 gives L=1; values above D give L=D.
  - Changes to cfg_words_per_pkt mid-packet have no effect until the next packet start.
- State IDLE:
  - On a cycle with cfg_enable=1 and i_tvalid=1, that word starts a packet.
  - If free space (D minus fill count, registered) is >= L: go to PASS and write the word.
  - Otherwise: go to DROP and discard the word. Set overflow=1 and increment drop_count (saturating).
  - Input in IDLE with cfg_enable=0 is ignored.
- Packet start from PASS/DROP:
  - A word arriving with word counter == L-1 ends the current packet.
  - On that boundary, if cfg_enable=1, the next valid word starts a new packet with the same admission test.
  - If cfg_enable=0, go to IDLE.
- State PASS: each valid word is written with tlast = (count == L-1); the counter increments and then wraps to 0.
- State DROP: each valid word is counted identically but not written. This keeps packet boundaries time-aligned.
- cfg_enable deasserted mid-packet: the current packet runs to completion (PASS or DROP) before IDLE. No truncated packets are produced.
- Guarantees:
  - Admission reserves L entries, so a write in PASS never hits a full FIFO.
  - The FIFO stores 65 bits per entry: tlast plus data.
- Output handshake:
  - A transfer occurs when o_tvalid & o_tready.
  - o_tdata/o_tlast hold stable while o_tvalid=1 and o_tready=0.
  - A word written at cycle t is visible at the output at t+1 at the earliest.
  - Sustained throughput is 1 word/cycle.
- Simultaneous read and write: the fill count is updated by both in the same cycle. Free space uses the pre-update count, which is conservative.
- clear_overflow:
  - Clears overflow and drop_count in the cycle after the pulse.
  - If a drop occurs in that same cycle, the result is overflow=1 and drop_count=1.
- i_tvalid gaps are allowed; only valid words are counted.

Test Plan:
- D=32, L=4, o_tready=1, cfg_enable=1, 12 consecutive words 0..11 → 3 packets; o_tlast on words 3, 7, 11; each word appears 1 cycle after input; overflow=0.
- L=8, o_tready=0, 40 words → first 32 stored (4 packets), words 32..39 dropped; drop_count=1, overflow=1. Then o_tready=1 → exactly 32 words out with 4 o_tlast, last data=31.
- L=4, cfg_enable dropped after word 1 of a packet → words 2 and 3 still written, o_tlast on word 3, then IDLE; words 4..7 ignored; active falls after word 3.
- i_tvalid toggling 1,0,0,1,… with L=3 → o_tlast on every third valid word only; output data order preserved.
- cfg_words_per_pkt=0 → every word has o_tlast; cfg_words_per_pkt=100 with D=32 → packets of 32 words.
- Assert rst while a packet is half written with o_tvalid=1 → all outputs zero immediately, FIFO empty. Release with cfg_enable=1 → the next valid word starts a fresh packet with counter 0.
